// File: rtl/data_mem.sv
// data_mem: word-addressed data memory for the processor's memory stage.
//
// 2**INDEX_BITS words of DATA_WIDTH bits. Writes happen on the rising edge of
// clk; reads are purely combinational. Only the low INDEX_BITS bits of Address
// pick a word, so higher addresses alias onto the same storage. A synchronous
// reset clears every word.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears the whole array
//   DataIn       write data
//   Address      word address, only Address[INDEX_BITS-1:0] is used
//   MemoryRead   read enable; DataOut is zero when low
//   MemoryWrite  write enable
//   DataOut      combinational read data
module data_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    output logic [DATA_WIDTH-1:0] DataOut
);

    localparam int Depth = 2 ** INDEX_BITS;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [INDEX_BITS-1:0] index;

    assign index = Address[INDEX_BITS-1:0];

    // Upper address bits are deliberately ignored (addresses alias modulo Depth).
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[ADDR_WIDTH-1:INDEX_BITS];

    // Reset wins over a write in the same cycle; that write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemoryWrite) begin
            mem_q[index] <= DataIn;
        end
    end

    // No write-through: a same-cycle write only becomes visible after the edge.
    always_comb begin
        DataOut = '0;
        if (MemoryRead) begin
            DataOut = mem_q[index];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem. Expected read values are pushed onto a
// scoreboard queue when the stimulus is driven and popped when DataOut is
// sampled. Directed checks use fixed constants; a short random phase uses a
// small reference model of the memory.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] DataIn;
    logic [31:0] Address;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [15:0] DataOut;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];
    logic [15:0] model [2048];

    always #5 clk = ~clk;

    data_mem #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32),
        .INDEX_BITS(11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .DataIn     (DataIn),
        .Address    (Address),
        .MemoryRead (MemoryRead),
        .MemoryWrite(MemoryWrite),
        .DataOut    (DataOut)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: DataOut=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [15:0] d, input logic rd,
                         input logic wr, input logic r);
        Address     = a;
        DataIn      = d;
        MemoryRead  = rd;
        MemoryWrite = wr;
        rst         = r;
    endtask

    // Push expectation now, let combinational logic settle, then pop and compare.
    task automatic expect_val(input string tag, input logic [15:0] exp);
        logic [15:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, DataOut, e);
    endtask

    // One rising edge; the model follows the same rules, then back to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2048; i++) model[i] = 16'h0000;
        end else if (MemoryWrite) begin
            model[Address[10:0]] = DataIn;
        end
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [15:0] d);
        drive(a, d, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic read_word(input string tag, input logic [31:0] a, input logic [15:0] exp);
        drive(a, 16'h0000, 1'b1, 1'b0, 1'b0);
        expect_val(tag, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [15:0] rd;
        logic [31:0] addrs [4];

        drive(32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tick();
        tick();

        // 1: everything reads zero after reset
        addrs[0] = 32'h0;
        addrs[1] = 32'h1;
        addrs[2] = 32'h8;
        addrs[3] = 32'h7FF;
        for (int i = 0; i < 4; i++) read_word($sformatf("rst_rd_%0h", addrs[i]), addrs[i], 16'h0000);

        // 2: overwrite and retention
        write_word(32'h1, 16'hFFFF);
        read_word("ow_ffff", 32'h1, 16'hFFFF);
        write_word(32'h1, 16'h0000);
        read_word("ow_0000", 32'h1, 16'h0000);
        write_word(32'h8, 16'h0DDF);
        write_word(32'h7FF, 16'hEB5A);
        read_word("rd_7ff", 32'h7FF, 16'hEB5A);
        read_word("retain_8", 32'h8, 16'h0DDF);

        // 3: aliasing and read-enable gating
        write_word(32'h0000_0805, 16'h1234);
        read_word("alias_5", 32'h5, 16'h1234);
        drive(32'h5, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_val("rd_gate", 16'h0000);
        read_word("alias_hi_rd", 32'hFFFF_F805, 16'h1234);

        // 4: read and write together, no write-through
        write_word(32'h3, 16'hAAAA);
        drive(32'h3, 16'h5555, 1'b1, 1'b1, 1'b0);
        expect_val("rw_before", 16'hAAAA);
        @(posedge clk);
        #1;
        expect_val("rw_after", 16'h5555);
        @(negedge clk);
        drive(32'h4, 16'h9999, 1'b1, 1'b1, 1'b0);
        expect_val("w4_before", 16'h0000);
        tick();
        read_word("rd3_after_w4", 32'h3, 16'h5555);
        read_word("rd4", 32'h4, 16'h9999);

        // 5: reset priority; pre-reset contents visible while rst is high
        drive(32'h8, 16'h0, 1'b1, 1'b0, 1'b1);
        expect_val("rst_shows_old", 16'h0DDF);
        drive(32'h2, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        tick();
        read_word("rst_drops_wr", 32'h2, 16'h0000);
        read_word("rst_clr_8", 32'h8, 16'h0000);
        read_word("rst_clr_7ff", 32'h7FF, 16'h0000);

        // 6: no write without MemoryWrite
        drive(32'h9, 16'h7777, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        read_word("no_wr_9", 32'h9, 16'h0000);

        // Random writes against the reference model, including aliasing addresses
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(0, 32'h0000_1FFF) & 32'h0000_003F | ($urandom() & 32'hFFFF_F800);
            rd = 16'($urandom());
            write_word(ra, rd);
        end
        for (int i = 0; i < 16; i++) begin
            ra = 32'(i) | ($urandom() & 32'hFFFF_F800);
            read_word($sformatf("rand_rd_%0d", i), ra, model[ra[10:0]]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
